// File: rtl/mv_pkg.sv
// Shared definitions for the motion-vector reference fetch block:
// MV field positions, fractional phase width and fetch FSM encoding.
package mv_pkg;

  localparam int MV_H_MSB = 7;
  localparam int MV_H_LSB = 4;
  localparam int MV_V_MSB = 3;
  localparam int MV_V_LSB = 0;
  localparam int MV_C_W   = MV_H_MSB - MV_H_LSB + 1;
  localparam int FRAC_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/mv_coord_clamp.sv
// Clamps a signed coordinate into [0, LIMIT]; out-of-frame reads replicate
// the nearest edge pixel.
module mv_coord_clamp #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 6,
  parameter int LIMIT = 63
) (
  input  logic signed [IN_W-1:0]  coord,
  output logic        [OUT_W-1:0] clamped
);

  localparam logic signed [IN_W-1:0] LIM_S = IN_W'(LIMIT);

  // Saturate below zero and above the frame edge, pass through otherwise.
  always_comb begin
    if (coord < 0) begin
      clamped = '0;
    end else if (coord > LIM_S) begin
      clamped = OUT_W'(LIMIT);
    end else begin
      clamped = coord[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mv_ref_fetch_gen.sv
// Reference window address generator for quarter-pel motion compensation.
// Splits the packed MV into integer offset and fractional phase, then walks
// the (BLK_W+TAPS-1) x (BLK_H+TAPS-1) filter window issuing one clamped
// pixel address per accepted transfer.
// Optional build macro MV_FRAC_SKIP_EN: drop filter padding in any dimension
// whose fractional phase is zero.
module mv_ref_fetch_gen
  import mv_pkg::*;
#(
  parameter int BLK_W   = 8,
  parameter int BLK_H   = 8,
  parameter int TAPS    = 8,
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ADDR_W  = 12
) (
  input  logic                       CLK,
  input  logic                       RST_SYNC,
  input  logic                       START,
  input  logic [7:0]                 MV_IN,
  input  logic [$clog2(FRAME_W)-1:0] BLK_X,
  input  logic [$clog2(FRAME_H)-1:0] BLK_Y,
  input  logic                       RD_READY,
  output logic                       RD_VALID,
  output logic [ADDR_W-1:0]          RD_ADDR,
  output logic                       RD_ROW_LAST,
  output logic [FRAC_W-1:0]          FRAC_H,
  output logic [FRAC_W-1:0]          FRAC_V,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int XW    = $clog2(FRAME_W);
  localparam int YW    = $clog2(FRAME_H);
  localparam int CXW   = XW + 3;
  localparam int CYW   = YW + 3;
  localparam int WIN_W = BLK_W + TAPS - 1;
  localparam int WIN_H = BLK_H + TAPS - 1;
  localparam int CNT_W = $clog2(((WIN_W > WIN_H) ? WIN_W : WIN_H) + 1);
  localparam int PAD   = TAPS / 2 - 1;

  fetch_state_t             state;
  logic signed [MV_C_W-1:0] mvx_r, mvy_r;
  logic [XW-1:0]            bx_r;
  logic [YW-1:0]            by_r;
  logic signed [CXW-1:0]    x0;
  logic signed [CYW-1:0]    y0;
  logic [CNT_W-1:0]         col, row, w_last, h_last;

  logic signed [CXW-1:0]    mvx_ext, int_x, bx_ext, x0_nxt;
  logic signed [CYW-1:0]    mvy_ext, int_y, by_ext, y0_nxt;
  logic [CNT_W-1:0]         w_last_nxt, h_last_nxt;

  logic signed [CXW-1:0]    x_cur;
  logic signed [CYW-1:0]    y_cur;
  logic [XW-1:0]            x_cl;
  logic [YW-1:0]            y_cl;

  // Window origin and extent derived from the latched MV and block origin.
  always_comb begin
    mvx_ext    = {{(CXW-MV_C_W){mvx_r[MV_C_W-1]}}, mvx_r};
    mvy_ext    = {{(CYW-MV_C_W){mvy_r[MV_C_W-1]}}, mvy_r};
    int_x      = mvx_ext >>> 2;
    int_y      = mvy_ext >>> 2;
    bx_ext     = {3'b000, bx_r};
    by_ext     = {3'b000, by_r};
    x0_nxt     = bx_ext + int_x - CXW'(PAD);
    y0_nxt     = by_ext + int_y - CYW'(PAD);
    w_last_nxt = CNT_W'(WIN_W - 1);
    h_last_nxt = CNT_W'(WIN_H - 1);
`ifdef MV_FRAC_SKIP_EN
    if (mvx_r[FRAC_W-1:0] == '0) begin
      x0_nxt     = bx_ext + int_x;
      w_last_nxt = CNT_W'(BLK_W - 1);
    end
    if (mvy_r[FRAC_W-1:0] == '0) begin
      y0_nxt     = by_ext + int_y;
      h_last_nxt = CNT_W'(BLK_H - 1);
    end
`endif
  end

  assign x_cur = x0 + $signed(CXW'(col));
  assign y_cur = y0 + $signed(CYW'(row));

  mv_coord_clamp #(.IN_W(CXW), .OUT_W(XW), .LIMIT(FRAME_W - 1)) u_clamp_x (
    .coord   (x_cur),
    .clamped (x_cl)
  );

  mv_coord_clamp #(.IN_W(CYW), .OUT_W(YW), .LIMIT(FRAME_H - 1)) u_clamp_y (
    .coord   (y_cur),
    .clamped (y_cl)
  );

  // Power-of-two frame width turns y*FRAME_W + x into a concatenation.
  assign RD_ADDR     = ADDR_W'({y_cl, x_cl});
  assign RD_ROW_LAST = RD_VALID & (col == w_last);

  // Fetch sequencer: latch request, compute window, walk it, pulse DONE.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state    <= S_IDLE;
      RD_VALID <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      FRAC_H   <= '0;
      FRAC_V   <= '0;
      x0       <= '0;
      y0       <= '0;
      col      <= '0;
      row      <= '0;
      w_last   <= '0;
      h_last   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            mvx_r <= MV_IN[MV_H_MSB:MV_H_LSB];
            mvy_r <= MV_IN[MV_V_MSB:MV_V_LSB];
            bx_r  <= BLK_X;
            by_r  <= BLK_Y;
            BUSY  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          x0       <= x0_nxt;
          y0       <= y0_nxt;
          w_last   <= w_last_nxt;
          h_last   <= h_last_nxt;
          FRAC_H   <= mvx_r[FRAC_W-1:0];
          FRAC_V   <= mvy_r[FRAC_W-1:0];
          col      <= '0;
          row      <= '0;
          RD_VALID <= 1'b1;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          if (RD_READY) begin
            if (col == w_last) begin
              col <= '0;
              if (row == h_last) begin
                row      <= '0;
                RD_VALID <= 1'b0;
                BUSY     <= 1'b0;
                DONE     <= 1'b1;
                state    <= S_DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_ref_fetch_gen.sv
// Randomised and directed bench for mv_ref_fetch_gen with a window-walk
// reference model computed from MV arithmetic and frame clamping.
module tb_mv_ref_fetch_gen;

  localparam int BLK_W   = 8;
  localparam int BLK_H   = 8;
  localparam int TAPS    = 8;
  localparam int FRAME_W = 64;
  localparam int FRAME_H = 64;
  localparam int ADDR_W  = 12;

  logic        CLK;
  logic        RST_SYNC;
  logic        START;
  logic [7:0]  MV_IN;
  logic [5:0]  BLK_X;
  logic [5:0]  BLK_Y;
  logic        RD_READY;
  logic        RD_VALID;
  logic [ADDR_W-1:0] RD_ADDR;
  logic        RD_ROW_LAST;
  logic [1:0]  FRAC_H;
  logic [1:0]  FRAC_V;
  logic        BUSY;
  logic        DONE;

  mv_ref_fetch_gen #(
    .BLK_W(BLK_W), .BLK_H(BLK_H), .TAPS(TAPS),
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RST_SYNC(RST_SYNC), .START(START), .MV_IN(MV_IN),
    .BLK_X(BLK_X), .BLK_Y(BLK_Y), .RD_READY(RD_READY), .RD_VALID(RD_VALID),
    .RD_ADDR(RD_ADDR), .RD_ROW_LAST(RD_ROW_LAST), .FRAC_H(FRAC_H),
    .FRAC_V(FRAC_V), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int exp_addr[$];
  bit exp_last[$];
  int exp_fh, exp_fv;

  int obs_addr[$];
  bit obs_last[$];
  int first_lat, done_lat, last_cyc, stall_err, busy_err;
  bit timed_out, saw_done, done_wide, after_busy;

  // Reference: enumerate the filter window row by row with edge clamping.
  task automatic build_ref(input logic [7:0] mv, input int bx, input int by);
    int mvx, mvy, ix, iy, pad, w, h, lx, ly, x, y;
    mvx = int'(mv[7:4]); if (mvx > 7) mvx -= 16;
    mvy = int'(mv[3:0]); if (mvy > 7) mvy -= 16;
    ix = (mvx >= 0) ? mvx / 4 : -((3 - mvx) / 4);
    iy = (mvy >= 0) ? mvy / 4 : -((3 - mvy) / 4);
    exp_fh = mvx - 4 * ix;
    exp_fv = mvy - 4 * iy;
    pad = TAPS / 2 - 1;
    w = BLK_W + TAPS - 1; h = BLK_H + TAPS - 1;
    lx = bx + ix - pad;   ly = by + iy - pad;
`ifdef MV_FRAC_SKIP_EN
    if (exp_fh == 0) begin w = BLK_W; lx = bx + ix; end
    if (exp_fv == 0) begin h = BLK_H; ly = by + iy; end
`endif
    exp_addr.delete(); exp_last.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = lx + c; y = ly + r;
        if (x < 0) x = 0; if (x > FRAME_W - 1) x = FRAME_W - 1;
        if (y < 0) y = 0; if (y > FRAME_H - 1) y = FRAME_H - 1;
        exp_addr.push_back(y * FRAME_W + x);
        exp_last.push_back(c == w - 1);
      end
    end
  endtask

  // Number of positions where the observed transfer stream departs from the model.
  function automatic int seq_diffs(input bit prefix_only);
    int d, n;
    d = 0;
    if (!prefix_only && obs_addr.size() != exp_addr.size()) d++;
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (obs_addr[i] != exp_addr[i]) d++;
      if (obs_last[i] != exp_last[i]) d++;
    end
    return d;
  endfunction

  // Drive one request and record the accepted transfers.
  // ready_mode: <0 -> 1,0,0,1 pattern, otherwise percent chance of ready.
  task automatic run_fetch(input logic [7:0] mv, input int bx, input int by,
                           input int ready_mode, input int start_at, input int rst_at);
    int cyc, nx, stall_addr;
    bit stalled, rdy, first_seen;
    obs_addr.delete(); obs_last.delete();
    first_lat = -1; done_lat = -1; last_cyc = 0; stall_err = 0; busy_err = 0;
    timed_out = 0; saw_done = 0; done_wide = 0; after_busy = 0;
    stalled = 0; first_seen = 0; stall_addr = 0;
    START = 1'b1; MV_IN = mv; BLK_X = bx[5:0]; BLK_Y = by[5:0];
    @(posedge CLK); #1;
    START = 1'b0; cyc = 1;
    while (cyc < 3000) begin
      if (RD_VALID) begin
        if (!first_seen) begin first_lat = cyc; first_seen = 1; end
        if (stalled && int'(RD_ADDR) != stall_addr) stall_err++;
        if (!BUSY) busy_err++;
        nx = obs_addr.size();
        if (rst_at >= 0 && nx == rst_at) begin
          RD_READY = 1'b0; RST_SYNC = 1'b1;
          @(posedge CLK); #1;
          RST_SYNC = 1'b0;
          return;
        end
        if (start_at >= 0 && nx == start_at) begin
          START = 1'b1; MV_IN = ~mv;
        end
        if (ready_mode < 0) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        else                rdy = ($urandom_range(99) < ready_mode);
        RD_READY = rdy;
        if (rdy) begin
          obs_addr.push_back(int'(RD_ADDR));
          obs_last.push_back(RD_ROW_LAST);
          last_cyc = cyc;
        end
        stalled = !rdy; stall_addr = int'(RD_ADDR);
      end else begin
        RD_READY = 1'($urandom_range(1));
      end
      if (DONE) begin
        saw_done = 1; done_lat = cyc - last_cyc;
        @(posedge CLK); #1;
        done_wide = DONE; after_busy = BUSY; RD_READY = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      START = 1'b0; cyc++;
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    RST_SYNC = 1'b1;
    repeat (3) @(posedge CLK);
    #1; RST_SYNC = 1'b0;
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", RD_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
    checks++; if (RD_ROW_LAST !== 1'b0) begin errors++; $display("FAIL reset_row_last got %b want 0", RD_ROW_LAST); end
    checks++; if (RD_ADDR !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", RD_ADDR); end
    checks++; if (FRAC_H !== 2'd0 || FRAC_V !== 2'd0) begin
      errors++; $display("FAIL reset_frac got %0d/%0d want 0/0", FRAC_H, FRAC_V); end
  endtask

  task automatic test_directed();
    logic [7:0] mvs[3];
    int bxs[3], fhs[3], fvs[3], firsts[3], lasts[3];
    int f, l;
    mvs = '{8'h00, 8'hF5, 8'h77};
    bxs = '{16, 0, 56};
    fhs = '{0, 3, 3};
    fvs = '{0, 1, 3};
    firsts = '{845, 0, 3510};
    lasts  = '{1755, 778, 4095};
    for (int i = 0; i < 3; i++) begin
      build_ref(mvs[i], bxs[i], bxs[i]);
      run_fetch(mvs[i], bxs[i], bxs[i], 100, -1, -1);
      checks++; if (timed_out) begin errors++; $display("FAIL dir%0d_timeout got no DONE within bound", i); end
      checks++; if (seq_diffs(0) !== 0) begin errors++;
        $display("FAIL dir%0d_seq got %0d diffs (%0d xfers) want 0 (%0d xfers)", i, seq_diffs(0), obs_addr.size(), exp_addr.size()); end
      checks++; if (int'(FRAC_H) !== fhs[i] || int'(FRAC_V) !== fvs[i]) begin errors++;
        $display("FAIL dir%0d_frac got %0d/%0d want %0d/%0d", i, FRAC_H, FRAC_V, fhs[i], fvs[i]); end
      checks++; if (first_lat !== 2) begin errors++; $display("FAIL dir%0d_first_latency got %0d want 2", i, first_lat); end
      checks++; if (!saw_done || done_lat !== 1) begin errors++; $display("FAIL dir%0d_done_latency got %0d want 1", i, done_lat); end
      checks++; if (done_wide !== 1'b0 || after_busy !== 1'b0) begin errors++;
        $display("FAIL dir%0d_done_pulse got done=%b busy=%b want 0/0", i, done_wide, after_busy); end
`ifndef MV_FRAC_SKIP_EN
      f = (obs_addr.size() > 0) ? obs_addr[0] : -1;
      l = (obs_addr.size() > 0) ? obs_addr[obs_addr.size()-1] : -1;
      checks++; if (obs_addr.size() !== 225) begin errors++; $display("FAIL dir%0d_count got %0d want 225", i, obs_addr.size()); end
      checks++; if (f !== firsts[i] || l !== lasts[i]) begin errors++;
        $display("FAIL dir%0d_ends got %0d..%0d want %0d..%0d", i, f, l, firsts[i], lasts[i]); end
`else
      f = 0; l = 0;
`endif
    end
`ifdef MV_FRAC_SKIP_EN
    build_ref(8'h40, 8, 8);
    run_fetch(8'h40, 8, 8, 100, -1, -1);
    checks++; if (obs_addr.size() !== 64 || seq_diffs(0) !== 0) begin errors++;
      $display("FAIL skip_seq got %0d xfers %0d diffs want 64 xfers 0 diffs", obs_addr.size(), seq_diffs(0)); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] mv; int bx, by;
    for (int i = 0; i < 8; i++) begin
      mv = 8'($urandom); bx = $urandom_range(FRAME_W - 1); by = $urandom_range(FRAME_H - 1);
      build_ref(mv, bx, by);
      run_fetch(mv, bx, by, 60, -1, -1);
      checks++; if (timed_out || seq_diffs(0) !== 0) begin errors++;
        $display("FAIL rand%0d_seq mv=%02h blk=%0d,%0d got %0d diffs timeout=%b want 0", i, mv, bx, by, seq_diffs(0), timed_out); end
      checks++; if (int'(FRAC_H) !== exp_fh || int'(FRAC_V) !== exp_fv) begin errors++;
        $display("FAIL rand%0d_frac got %0d/%0d want %0d/%0d", i, FRAC_H, FRAC_V, exp_fh, exp_fv); end
      checks++; if (stall_err !== 0 || busy_err !== 0 || done_lat !== 1) begin errors++;
        $display("FAIL rand%0d_flow got stall=%0d busy=%0d done_lat=%0d want 0/0/1", i, stall_err, busy_err, done_lat); end
    end
  endtask

  task automatic test_stall();
    build_ref(8'hC3, 30, 5);
    run_fetch(8'hC3, 30, 5, -1, -1, -1);
    checks++; if (timed_out || seq_diffs(0) !== 0) begin errors++;
      $display("FAIL stall_seq got %0d diffs (%0d xfers) want 0 (%0d xfers)", seq_diffs(0), obs_addr.size(), exp_addr.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold got %0d moves want 0", stall_err); end
  endtask

  task automatic test_start_ignored();
    build_ref(8'h3D, 20, 30);
    run_fetch(8'h3D, 20, 30, 100, 20, -1);
    checks++; if (timed_out || seq_diffs(0) !== 0) begin errors++;
      $display("FAIL start_mid_seq got %0d diffs want 0", seq_diffs(0)); end
    checks++; if (int'(FRAC_H) !== exp_fh || int'(FRAC_V) !== exp_fv) begin errors++;
      $display("FAIL start_mid_frac got %0d/%0d want %0d/%0d", FRAC_H, FRAC_V, exp_fh, exp_fv); end
  endtask

  task automatic test_reset_mid();
    int dseen;
    build_ref(8'h9A, 40, 12);
    run_fetch(8'h9A, 40, 12, 100, -1, 40);
    checks++; if (obs_addr.size() !== 40 || seq_diffs(1) !== 0) begin errors++;
      $display("FAIL rst_mid_prefix got %0d xfers %0d diffs want 40 xfers 0 diffs", obs_addr.size(), seq_diffs(1)); end
    checks++; if (RD_VALID !== 1'b0 || BUSY !== 1'b0 || RD_ADDR !== '0 || DONE !== 1'b0) begin errors++;
      $display("FAIL rst_mid_outputs got valid=%b busy=%b addr=%0d done=%b want 0/0/0/0", RD_VALID, BUSY, RD_ADDR, DONE); end
    dseen = 0;
    repeat (3) begin @(posedge CLK); #1; if (DONE || RD_VALID) dseen++; end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", dseen); end
    run_fetch(8'h9A, 40, 12, 100, -1, -1);
    checks++; if (timed_out || seq_diffs(0) !== 0) begin errors++;
      $display("FAIL rst_restart_seq got %0d diffs want 0", seq_diffs(0)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mv; int bx, by;
    for (int i = 0; i < 2; i++) begin
      mv = 8'($urandom); bx = $urandom_range(FRAME_W - 1); by = $urandom_range(FRAME_H - 1);
      build_ref(mv, bx, by);
      run_fetch(mv, bx, by, 100, -1, -1);
      checks++; if (timed_out || seq_diffs(0) !== 0 || first_lat !== 2) begin errors++;
        $display("FAIL b2b%0d_seq got %0d diffs first_lat=%0d want 0 diffs 2", i, seq_diffs(0), first_lat); end
    end
  endtask

  initial begin
    RST_SYNC = 1'b1; START = 1'b0; MV_IN = '0; BLK_X = '0; BLK_Y = '0; RD_READY = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
